ifu_fetch_ctrl: RTL and testbench

Multi-cycle instruction fetch unit that replaces the single-cycle fetch path. It sits between the PC/writeback logic and the decoder.
- Accepts the next PC once the previous instruction retires, fetches the word over a valid/ready instruction-memory bus, and presents it to the IDU under a valid/ready handshake.
- Detects misaligned PCs, bus errors and response timeouts.

---
 rtl/ysyx_23060059_ifu_pkg.sv | 26 ++
 rtl/ifu_timeout_ctr.sv | 38 +++
 rtl/ifu_fetch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060059_ifu_pkg.sv
// Shared types for the instruction fetch unit: FSM state encoding, fault
// cause codes and the default boot address.
package ysyx_23060059_ifu_pkg;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_IDLE = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_HOLD = 3'd4
  } ifu_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_BUS_ERR  = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } fetch_cause_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_timeout_ctr.sv
// Response timeout for the fetch unit: loaded on clear, counts down while
// enabled, and pulses expire_o on the TIMEOUT_CYC-th enabled cycle.
module ifu_timeout_ctr #(
  parameter  int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [TW-1:0] TC_LOAD = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = TC_LOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count reached while waiting: this is WAIT cycle TIMEOUT_CYC.
  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Multi-cycle instruction fetch controller between PC select and decode.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
module ifu_fetch_ctrl
  import ysyx_23060059_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = IFU_RESET_PC,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        ifu_ready,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        ifu_send_valid,
  input  logic        ifu_send_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        fetch_err,
  output logic [1:0]  fetch_cause,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  ifu_state_e   state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  fetch_cause_e cause_q, cause_d;
  logic         stale_q, stale_d;

  logic in_req, in_wait, in_hold;
  logic req_fire;
  logic tmr_clr, tmr_expire;

  assign in_req   = (state_q == ST_REQ);
  assign in_wait  = (state_q == ST_WAIT);
  assign in_hold  = (state_q == ST_HOLD);
  // A timed-out request still owes us a response; keep the bus quiet until it lands.
  assign req_fire = in_req && !stale_q && imem_req_ready;

  ifu_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmr_clr),
    .en_i     (in_wait),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cause_d = cause_q;
    stale_d = stale_q;
    tmr_clr = 1'b0;

    if (imem_resp_valid && stale_q) begin
      stale_d = 1'b0;
    end

    unique case (state_q)
      ST_BOOT: begin
        pc_d    = RESET_PC;
        state_d = ST_REQ;
      end
      ST_IDLE: begin
        if (pc_valid) begin
          pc_d = pc_in;
          if (pc_in[1:0] != 2'b00) begin
            inst_d  = '0;
            cause_d = CAUSE_MISALIGN;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (req_fire) begin
          tmr_clr = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response coinciding with expiry wins over the timeout.
        if (imem_resp_valid) begin
          inst_d  = imem_resp_data;
          cause_d = imem_resp_err ? CAUSE_BUS_ERR : CAUSE_NONE;
          state_d = ST_HOLD;
        end else if (tmr_expire) begin
          inst_d  = '0;
          cause_d = CAUSE_TIMEOUT;
          stale_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ifu_send_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cause_q <= CAUSE_NONE;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cause_q <= cause_d;
      stale_q <= stale_d;
    end
  end

  // Outputs decode from registered state only, so they drop to zero in reset.
  assign ifu_ready      = (state_q == ST_IDLE);
  assign imem_req_valid = in_req && !stale_q;
  assign imem_addr      = in_req ? word_align(pc_q) : '0;
  assign ifu_send_valid = in_hold;
  assign instruction    = in_hold ? inst_q : '0;
  assign inst_pc        = in_hold ? pc_q : '0;
  assign fetch_err      = in_hold && (cause_q != CAUSE_NONE);
  assign fetch_cause    = in_hold ? cause_q : CAUSE_NONE;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (in_hold && ifu_send_ready) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (in_req || in_wait) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

  property p_no_unsolicited_resp;
    @(posedge clk) disable iff (!rst)
      imem_resp_valid |-> (stale_q || in_wait);
  endproperty
  a_no_unsolicited_resp: assert property (p_no_unsolicited_resp);

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl: directed boot/reset sequences, a
// table of single fetches and randomized fetches against a transaction model.
module tb_ifu_fetch_ctrl;

  localparam int unsigned TO = 8;
`ifdef IFU_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        ifu_ready;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        ifu_send_valid;
  logic        ifu_send_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        fetch_err;
  logic [1:0]  fetch_cause;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  always #5 clk = ~clk;

  ifu_fetch_ctrl #(
    .RESET_PC    (32'h8000_0000),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_in           (pc_in),
    .pc_valid        (pc_valid),
    .ifu_ready       (ifu_ready),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .ifu_send_valid  (ifu_send_valid),
    .ifu_send_ready  (ifu_send_ready),
    .instruction     (instruction),
    .inst_pc         (inst_pc),
    .fetch_err       (fetch_err),
    .fetch_cause     (fetch_cause),
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Memory model: one outstanding request, response dl cycles after acceptance.
  bit          pend;
  int          dl;
  logic [31:0] p_addr;
  bit          p_err;
  int          overlap;
  int          n_fetch;

  typedef struct {
    logic [31:0] pc;
    int          d;
    bit          err;
    int          rs;
    int          ss;
    logic [1:0]  cause;
    bit          from_mem;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0073;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [1:0] model_cause(input logic [31:0] pc, input int d, input bit err);
    if (pc[1:0] != 2'b00) return 2'b01;
    if (d >= int'(TO)) return 2'b11;
    return err ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [31:0] exp_perf(input int n);
    return PERF_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    imem_resp_data  = '0;
    if (pend) begin
      if (imem_req_valid) overlap++;
      if (dl == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(p_addr);
        imem_resp_err   = p_err;
        pend = 1'b0;
      end else begin
        dl--;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ifu_ready"}, 32'(ifu_ready), 32'd0);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_addr"}, imem_addr, 32'd0);
    check({tag, "_send_valid"}, 32'(ifu_send_valid), 32'd0);
    check({tag, "_instruction"}, instruction, 32'd0);
    check({tag, "_inst_pc"}, inst_pc, 32'd0);
    check({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
    check({tag, "_fetch_cause"}, 32'(fetch_cause), 32'd0);
    check({tag, "_perf_fetch"}, perf_fetch_cnt, 32'd0);
    check({tag, "_perf_stall"}, perf_stall_cnt, 32'd0);
  endtask

  task automatic run_fetch(input string tag, input logic [31:0] pc, input bit issue,
                           input int d, input bit err, input int req_stall, input int send_stall,
                           input bit noise, input logic [1:0] e_cause, input logic [31:0] e_inst);
    int rs, ss, acc_at, sv_at, hold_n, unstable_addr, unstable_out;
    bit done, seen_req, seen_sv;
    logic [31:0] a0, i0, p0;
    logic [2:0]  c0;
    rs = 0; ss = 0; acc_at = -1; sv_at = -1; hold_n = 0;
    unstable_addr = 0; unstable_out = 0;
    done = 1'b0; seen_req = 1'b0; seen_sv = 1'b0;
    a0 = '0; i0 = '0; p0 = '0; c0 = '0;
    overlap = 0;
    if (issue) begin
      for (int w = 0; w < 64 && !ifu_ready; w++) tick();
      check({tag, "_ready_before"}, 32'(ifu_ready), 32'd1);
      pc_in = pc;
      pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0;
    end
    for (int c = 0; c < 200 && !done; c++) begin
      imem_req_ready = 1'b0;
      ifu_send_ready = 1'b0;
      pc_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      pc_in = $urandom;
      if (imem_req_valid) begin
        if (!seen_req) begin
          a0 = imem_addr;
          seen_req = 1'b1;
        end else if (imem_addr !== a0) begin
          unstable_addr++;
        end
        if (rs < req_stall) begin
          rs++;
        end else begin
          imem_req_ready = 1'b1;
          pend = 1'b1;
          dl = d;
          p_addr = imem_addr;
          p_err = err;
          acc_at = c;
        end
      end
      if (ifu_send_valid) begin
        if (!seen_sv) begin
          seen_sv = 1'b1;
          sv_at = c;
          i0 = instruction;
          p0 = inst_pc;
          c0 = {fetch_err, fetch_cause};
        end else if (instruction !== i0 || inst_pc !== p0 || {fetch_err, fetch_cause} !== c0) begin
          unstable_out++;
        end
        hold_n++;
        if (ss < send_stall) ss++;
        else begin
          ifu_send_ready = 1'b1;
          done = 1'b1;
        end
      end
      tick();
    end
    ifu_send_ready = 1'b0;
    imem_req_ready = 1'b0;
    pc_valid = 1'b0;
    if (done) n_fetch++;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_req_issued"}, 32'(seen_req), 32'(pc[1:0] == 2'b00));
    if (pc[1:0] == 2'b00) begin
      check({tag, "_addr"}, a0, {pc[31:2], 2'b00});
      check({tag, "_latency"}, 32'(sv_at - acc_at), (e_cause == 2'b11) ? 32'(TO + 1) : 32'(d + 2));
    end else begin
      check({tag, "_misalign_latency"}, 32'(sv_at), 32'd0);
    end
    check({tag, "_addr_stable"}, 32'(unstable_addr), 32'd0);
    check({tag, "_out_stable"}, 32'(unstable_out), 32'd0);
    check({tag, "_hold_cycles"}, 32'(hold_n), 32'(send_stall + 1));
    check({tag, "_instruction"}, i0, e_inst);
    check({tag, "_inst_pc"}, p0, pc);
    check({tag, "_fetch_err"}, 32'(c0[2]), 32'(e_cause != 2'b00));
    check({tag, "_fetch_cause"}, 32'(c0[1:0]), 32'(e_cause));
    check({tag, "_no_req_while_busy"}, 32'(overlap), 32'd0);
    check({tag, "_ready_after"}, 32'(ifu_ready), 32'd1);
    check({tag, "_perf_fetch"}, perf_fetch_cnt, exp_perf(n_fetch));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{32'h8000_0004, 5,  1'b0, 3, 2, 2'b00, 1'b1};
    tbl[1] = '{32'h8000_0006, 0,  1'b0, 0, 1, 2'b01, 1'b0};
    tbl[2] = '{32'h8000_0010, 2,  1'b1, 0, 0, 2'b10, 1'b1};
    tbl[3] = '{32'h8000_0014, 0,  1'b0, 0, 0, 2'b00, 1'b1};
    tbl[4] = '{32'h8000_0024, 7,  1'b0, 1, 0, 2'b00, 1'b1};
    tbl[5] = '{32'h8000_0040, 12, 1'b0, 0, 0, 2'b11, 1'b0};
    tbl[6] = '{32'h8000_0044, 0,  1'b0, 0, 1, 2'b00, 1'b1};
    tbl[7] = '{32'h0000_0003, 0,  1'b0, 0, 0, 2'b01, 1'b0};
    tbl[8] = '{32'h8000_0030, 8,  1'b0, 0, 0, 2'b11, 1'b0};
    tbl[9] = '{32'h8000_0034, 1,  1'b1, 2, 0, 2'b10, 1'b1};

    rst = 1'b0;
    pc_in = '0; pc_valid = 1'b0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; imem_resp_err = 1'b0;
    ifu_send_ready = 1'b0;
    pend = 1'b0; dl = 0; p_addr = '0; p_err = 1'b0; overlap = 0; n_fetch = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Boot fetch with zero-wait memory: REQ cycle 1, WAIT cycle 2, HOLD cycle 3.
    rst = 1'b1;
    tick();
    check("boot_c1_req_valid", 32'(imem_req_valid), 32'd1);
    check("boot_c1_addr", imem_addr, 32'h8000_0000);
    check("boot_c1_ifu_ready", 32'(ifu_ready), 32'd0);
    imem_req_ready = 1'b1;
    pend = 1'b1; dl = 0; p_addr = imem_addr; p_err = 1'b0;
    tick();
    imem_req_ready = 1'b0;
    check("boot_c2_send_valid", 32'(ifu_send_valid), 32'd0);
    check("boot_c2_resp_valid", 32'(imem_resp_valid), 32'd1);
    tick();
    check("boot_c3_send_valid", 32'(ifu_send_valid), 32'd1);
    check("boot_c3_instruction", instruction, 32'h0010_0073);
    check("boot_c3_inst_pc", inst_pc, 32'h8000_0000);
    check("boot_c3_fetch_err", 32'(fetch_err), 32'd0);
    check("boot_c3_perf_stall", perf_stall_cnt, PERF_EN ? 32'd2 : 32'd0);
    ifu_send_ready = 1'b1;
    tick();
    ifu_send_ready = 1'b0;
    n_fetch = 1;
    check("boot_ready_after", 32'(ifu_ready), 32'd1);
    check("boot_perf_fetch", perf_fetch_cnt, exp_perf(n_fetch));

    for (int i = 0; i < 10; i++) begin
      run_fetch($sformatf("tbl%0d", i), tbl[i].pc, 1'b1, tbl[i].d, tbl[i].err,
                tbl[i].rs, tbl[i].ss, 1'b0, tbl[i].cause,
                tbl[i].from_mem ? mem_word({tbl[i].pc[31:2], 2'b00}) : 32'h0);
    end

    for (int k = 0; k < 60; k++) begin
      logic [31:0] rpc;
      int          rd;
      bit          rerr;
      logic [1:0]  rc;
      rpc = $urandom;
      if ($urandom_range(0, 4) != 0) rpc[1:0] = 2'b00;
      case ($urandom_range(0, 5))
        0:       rd = int'(TO) - 1;
        1:       rd = int'(TO);
        2:       rd = int'(TO) + int'($urandom_range(1, 10));
        default: rd = int'($urandom_range(0, 4));
      endcase
      rerr = 1'($urandom_range(0, 1));
      rc = model_cause(rpc, rd, rerr);
      run_fetch($sformatf("rnd%0d", k), rpc, 1'b1, rd, rerr,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, rc,
                (rc == 2'b00 || rc == 2'b10) ? mem_word({rpc[31:2], 2'b00}) : 32'h0);
    end

    // Reset in the middle of WAIT abandons the fetch; memory forgets it too.
    for (int w = 0; w < 64 && pend; w++) tick();
    pc_in = 32'h8000_0050;
    pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    check("rstwait_req_valid", 32'(imem_req_valid), 32'd1);
    imem_req_ready = 1'b1;
    pend = 1'b1; dl = 6; p_addr = imem_addr; p_err = 1'b0;
    tick();
    imem_req_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_all_zero("rstwait");
    pend = 1'b0;
    imem_resp_valid = 1'b0;
    n_fetch = 0;
    tick();
    tick();
    rst = 1'b1;
    run_fetch("reboot", 32'h8000_0000, 1'b0, 0, 1'b0, 0, 0, 1'b0, 2'b00, 32'h0010_0073);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
